rr_mux_arb: RTL and testbench

RR_MUX_ARB -- requirements
Module: rr_mux_arb

---
 rtl/rr_mux_arb_pkg.sv | 4 +
 rtl/one_hot_mux.sv | 18 +
 rtl/rr_mux_arb.sv | 71 +++++++
 tb/tb_rr_mux_arb.sv | 128 ++++++++++++
 4 files changed

// File: rtl/rr_mux_arb_pkg.sv
// rr_mux_arb_pkg: shared FSM state encodings for the round-robin packet arbiter
package rr_mux_arb_pkg;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
endpackage

// File: rtl/one_hot_mux.sv
// one_hot_mux: AND-OR selector driven by a one-hot select, with optional one-hot checker
module one_hot_mux #(
    parameter int WIDTH = 8,
    parameter int CNT = 2,
    parameter int ONE_HOT_CHECK = 0
) (
    input  logic [CNT-1:0]       sel,
    input  logic [WIDTH*CNT-1:0] din,
    output logic [WIDTH-1:0]     dout,
    output logic                 err
);
    always_comb begin
        dout = '0;
        for (int i = 0; i < CNT; i++) dout |= din[i*WIDTH +: WIDTH] & {WIDTH{sel[i]}};
    end
    // more than one bit set implies a nonzero (owned) select
    assign err = (ONE_HOT_CHECK != 0) && ((sel & (sel - 1'b1)) != '0);
endmodule

// File: rtl/rr_mux_arb.sv
// rr_mux_arb: packet-locked round-robin arbiter muxing CNT requesters onto one output
module rr_mux_arb
    import rr_mux_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT = 5,
    parameter int ONE_HOT_CHECK = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CNT-1:0]       req_vld,
    input  logic [WIDTH*CNT-1:0] req_data,
    input  logic [CNT-1:0]       req_last,
    output logic [CNT-1:0]       req_rdy,
    output logic                 out_vld,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    input  logic                 out_rdy,
    output logic [CNT-1:0]       grant,
    output logic                 err
);
    localparam int PW = $clog2(CNT);
    state_t state, next_state;
    logic [PW-1:0] ptr, own, win, win_lo, win_hi;
    logic hi, done;
    logic [(WIDTH+1)*CNT-1:0] mux_in;
    // lowest requester at or above ptr wins, else lowest overall (wrap)
    always_comb begin
        win_lo = '0;
        win_hi = '0;
        hi = 1'b0;
        for (int i = CNT - 1; i >= 0; i--) begin
            if (req_vld[i]) win_lo = PW'(i);
            if (req_vld[i] && PW'(i) >= ptr) begin
                win_hi = PW'(i);
                hi = 1'b1;
            end
        end
    end
    assign win = hi ? win_hi : win_lo;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next_state;
    always_comb
        next_state = state == IDLE ? (|req_vld ? BUSY : IDLE) : (done ? IDLE : BUSY);
    always_comb begin
        out_vld = state == BUSY && |(req_vld & grant);
        req_rdy = state == BUSY ? grant & {CNT{out_rdy}} : '0;
        done = out_vld && out_rdy && out_last;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            grant <= '0;
            own <= '0;
            ptr <= '0;
        end else if (state == IDLE && |req_vld) begin
            grant <= CNT'(1) << win;
            own <= win;
        end else if (done) begin
            grant <= '0;
            ptr <= own == PW'(CNT - 1) ? '0 : own + 1'b1;
        end
    for (genvar g = 0; g < CNT; g++)
        assign mux_in[g*(WIDTH+1) +: WIDTH+1] = {req_last[g], req_data[g*WIDTH +: WIDTH]};
    one_hot_mux #(.WIDTH(WIDTH + 1), .CNT(CNT), .ONE_HOT_CHECK(ONE_HOT_CHECK)) u_mux (
        .sel (grant),
        .din (mux_in),
        .dout({out_last, out_data}),
        .err (err)
    );
endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: directed and random checks of rr_mux_arb against a packet-level reference model
module tb_rr_mux_arb;
    localparam int WIDTH = 32;
    localparam int CNT = 5;
    logic clk, rst_n, out_vld, out_last, out_rdy, err;
    logic [CNT-1:0] req_vld, req_last, req_rdy, grant;
    logic [WIDTH*CNT-1:0] req_data;
    logic [WIDTH-1:0] out_data;
    int tests = 0, fails = 0;
    int m_own = -1, m_ptr = 0;

    rr_mux_arb #(.WIDTH(WIDTH), .CNT(CNT), .ONE_HOT_CHECK(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_data(req_data),
        .req_last(req_last), .req_rdy(req_rdy), .out_vld(out_vld),
        .out_data(out_data), .out_last(out_last), .out_rdy(out_rdy),
        .grant(grant), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic check();
        logic [CNT-1:0] eg, er;
        logic [WIDTH-1:0] ed;
        logic ev, el;
        eg = m_own < 0 ? '0 : CNT'(1) << m_own;
        ed = m_own < 0 ? '0 : req_data[m_own*WIDTH +: WIDTH];
        el = m_own < 0 ? 1'b0 : req_last[m_own];
        ev = m_own >= 0 && req_vld[m_own];
        er = m_own >= 0 && out_rdy ? eg : '0;
        cmp("grant", 64'(grant), 64'(eg));
        cmp("out_vld", 64'(out_vld), 64'(ev));
        cmp("out_data", 64'(out_data), 64'(ed));
        cmp("out_last", 64'(out_last), 64'(el));
        cmp("req_rdy", 64'(req_rdy), 64'(er));
        cmp("err", 64'(err), 64'(0));
    endtask

    task automatic advance();
        if (m_own < 0) begin
            for (int k = 0; k < CNT; k++) begin
                int j = (m_ptr + k) % CNT;
                if (req_vld[j]) begin
                    m_own = j;
                    break;
                end
            end
        end else if (req_vld[m_own] && out_rdy && req_last[m_own]) begin
            m_ptr = (m_own + 1) % CNT;
            m_own = -1;
        end
    endtask

    task automatic step(input logic [CNT-1:0] v, input logic [CNT-1:0] l, input logic r);
        req_vld = v;
        req_last = l;
        out_rdy = r;
        for (int i = 0; i < CNT; i++) req_data[i*WIDTH +: WIDTH] = $urandom;
        #1 check();
        @(posedge clk);
        advance();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_own = -1;
        m_ptr = 0;
        check();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_vld = '0;
        req_last = '0;
        req_data = '0;
        out_rdy = 1'b0;
        do_reset();
        // two-beat packet from requester 2, then ptr=3 picks 3 over 2
        step(5'b00100, 5'b00000, 1'b1);
        step(5'b00100, 5'b00000, 1'b1);
        step(5'b00100, 5'b00100, 1'b1);
        step(5'b01100, 5'b00000, 1'b1);
        step(5'b01100, 5'b01000, 1'b1);
        // everyone requesting single-beat packets
        do_reset();
        repeat (12) step(5'b11111, 5'b11111, 1'b1);
        // owner 1 drops valid mid-packet while 2 waits
        step(5'b00010, 5'b00000, 1'b1);
        step(5'b00110, 5'b00000, 1'b1);
        repeat (3) step(5'b00100, 5'b00000, 1'b1);
        step(5'b00110, 5'b00010, 1'b1);
        step(5'b00000, 5'b00000, 1'b1);
        // stalled last beat
        step(5'b01000, 5'b00000, 1'b1);
        repeat (4) step(5'b01000, 5'b01000, 1'b0);
        step(5'b01000, 5'b01000, 1'b1);
        step(5'b00000, 5'b00000, 1'b0);
        // owner 4 finishes, pointer wraps to 0
        step(5'b10000, 5'b00000, 1'b1);
        step(5'b10001, 5'b10000, 1'b1);
        step(5'b10001, 5'b00000, 1'b1);
        step(5'b00001, 5'b00001, 1'b1);
        // reset mid-packet
        step(5'b00100, 5'b00000, 1'b1);
        step(5'b00100, 5'b00000, 1'b1);
        do_reset();
        repeat (3) step(5'b11111, 5'b11111, 1'b1);
        repeat (400) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            step(CNT'($urandom), CNT'($urandom), $urandom_range(0, 3) != 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
